mdu: RTL and testbench
======================

# mdu

Iterative RV32M multiply/divide unit. Sits directly downstream of the register bank: consumes the two read-port operands (rd1/rd2) plus the destination register index, and computes the M-extension result over a fixed multi-cycle latency. Returns the result and its destination index for the write-back path into the register bank's write port (wd3/a3). Uses a single shared 32-iteration radix-2 datapath: shift-add for multiply, restoring for divide.

## Interface
- No parameters. XLEN fixed at 32; iteration count fixed at 32.
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when the unit is ready (IDLE or DONE)
- funct3  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  in  32  rs1 value (from rd1)
- op_b  in  32  rs2 value (from rd2)
- rd_in  in  5  destination register index
- busy  out  1  high while computing (CALC, FIX)
- done  out  1  one-cycle pulse: result and rd_out valid
- result  out  32  computed value; held until the next done
- rd_out  out  5  destination index latched at start

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1: latch funct3, rd_in, |op_a|, |op_b|, and the sign flags. Clear the 64-bit accumulator. Count=0. Go to CALC.
- IDLE/DONE + start=0: go to (or stay in) IDLE.
- CALC: one iteration per cycle. After the 32nd iteration (count=31), go to FIX.
- FIX: apply sign correction and special cases, and load result. Go to DONE.
- DONE: done=1 for exactly one cycle. Returns to IDLE unless start=1.
- start in CALC/FIX is ignored. No queuing.
- Operands are latched at start. Changes on op_a/op_b/funct3/rd_in after that have no effect.
- Signedness of operands:
  - op_a is signed for MUL, MULH, MULHSU, DIV, REM.
  - op_b is signed for MUL, MULH, DIV, REM.
- Multiply: unsigned 32x32→64 on the magnitudes.
  - Negate the 64-bit product if the signs of the signed operands differ.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide: unsigned restoring division on the magnitudes.
  - Quotient is negated if sign_a≠sign_b.
  - Remainder takes the sign of the dividend.
- Special cases, resolved in FIX at the same latency:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- rd_in=0 is processed normally. The bank discards writes to x0.

## Timing
- Reset (rst_n=0, asynchronous, any state):
  - State=IDLE; busy=0, done=0, result=0, rd_out=0, count=0.
  - Takes effect immediately, including mid-CALC. The in-flight operation is dropped and no done is issued.
- Latency: start sampled at edge E0.
  - busy=1 from E0 to E33.
  - E1–E32 are the iterations; E33 is FIX.
  - At E34: busy=0, done=1, result valid.
  - The done cycle lies between E34 and E35: 34 cycles after acceptance, independent of operation and operands.
- Back-to-back: start=1 in the DONE cycle is accepted at E35. In that case done drops and busy rises at the same edge.
- result/rd_out change only at the FIX→DONE edge and hold their value until the next completion.
- busy and done are never high together.

## Test plan
- MUL 7×6, rd_in=5 → result=0x0000002A and rd_out=5, with done exactly 34 cycles after the start edge and busy high for cycles 1–33.
- 0x80000000 × 0x80000000:
  - MULH → 0x40000000.
  - MUL → 0x00000000.
- 0xFFFFFFFF × 0xFFFFFFFF:
  - MULHSU → 0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE.
- Division with mixed signs:
  - DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD.
  - REM of the same operands → 0xFFFFFFFF.
  - DIVU 7/2 → 3; REMU 7/2 → 1.
- Division special cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Each completes at the full 34-cycle latency.
- Handshake:
  - Pulse start at iteration 10 of an operation → ignored; original result unaffected.
  - Assert start in the DONE cycle → second operation accepted, its done follows 34 cycles later, first result held until then.
- Reset mid-operation:
  - Drop rst_n during iteration 10 → busy/done/result/rd_out go to 0 with no clock edge; no done pulse.
  - After release, MUL 3×3 → 9.

Source files
------------

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: one shared 32-step radix-2 datapath
// (shift-add multiply, restoring divide) with a fixed 34-cycle latency.
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DW    = 2 * XLEN;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [2:0]        fn;
  logic [4:0]        rd_q;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mq;
  logic [XLEN-1:0]   md;
  logic [DW-1:0]     acc;

  logic              a_signed;
  logic              b_signed;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [DW-1:0]     mul_next;
  logic [XLEN:0]     div_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [DW-1:0]     div_next;
  logic [DW-1:0]     prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_val;

  // Operand signedness and magnitudes, taken from the live request
  always_comb begin
    a_signed = (funct3 != 3'd3) && (funct3 != 3'd5) && (funct3 != 3'd7);
    b_signed = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    abs_a    = (a_signed && op_a[XLEN-1]) ? (~op_a + XLEN'(1)) : op_a;
    abs_b    = (b_signed && op_b[XLEN-1]) ? (~op_b + XLEN'(1)) : op_b;
  end

  // One MSB-first step: mq shifts out the multiplier (mul) or dividend (div)
  always_comb begin
    mul_next = {acc[DW-2:0], 1'b0} + (mq[XLEN-1] ? {XLEN'(0), md} : DW'(0));
    div_sh   = {acc[DW-1:XLEN], mq[XLEN-1]};
    div_diff = {1'b0, div_sh} - {2'b00, md};
    div_ge   = ~div_diff[XLEN+1];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
  end

  // Sign correction and divide-by-zero override; overflow falls out naturally
  always_comb begin
    prod    = (sign_a ^ sign_b) ? (~acc + DW'(1)) : acc;
    quo     = acc[XLEN-1:0];
    rem     = acc[DW-1:XLEN];
    fix_val = '0;
    case (fn)
      3'd0:                fix_val = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod[DW-1:XLEN];
      3'd4:                fix_val = (md == '0) ? '1 :
                                     ((sign_a ^ sign_b) ? (~quo + XLEN'(1)) : quo);
      3'd5:                fix_val = (md == '0) ? '1 : quo;
      3'd6:                fix_val = sign_a ? (~rem + XLEN'(1)) : rem;
      default:             fix_val = rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      fn     <= '0;
      rd_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mq     <= '0;
      md     <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            fn     <= funct3;
            rd_q   <= rd_in;
            sign_a <= a_signed & op_a[XLEN-1];
            sign_b <= b_signed & op_b[XLEN-1];
            mq     <= funct3[2] ? abs_a : abs_b;
            md     <= funct3[2] ? abs_b : abs_a;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          // 32 iterations, then one settle cycle before FIX
          if (count == CNT_W'(ITERS)) begin
            state <= FIX;
          end else begin
            acc   <= fn[2] ? div_next : mul_next;
            mq    <= {mq[XLEN-2:0], 1'b0};
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          result <= fix_val;
          rd_out <= rd_q;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed M-extension corner cases, handshake,
// asynchronous reset, and randomized operations against an arithmetic model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_hold = '0;
  logic [4:0]  rd_hold = '0;

  mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RV32M semantics straight from the ISA definition
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issues one op from the current (ready) cycle and follows it to done.
  // inject>0 pulses a stray start just before that iteration edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int inject);
    logic [31:0] exp;
    int lat, busy_cnt, hold_err, both;
    exp    = ref_mdu(f, a, b);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    rd_in  = 5'($urandom);
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_done", 32'(done), 32'd0);
    lat = 0; busy_cnt = 0; hold_err = 0; both = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == inject) begin
        start  = 1'b1;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy && done) both++;
      if (done) lat = k;
      else begin
        if (busy) busy_cnt++;
        if (result !== exp_hold || rd_out !== rd_hold) hold_err++;
      end
    end
    chk("latency", 32'(lat), 32'd34);
    chk("busy_cycles", 32'(busy_cnt), 32'd33);
    chk("result_hold", 32'(hold_err), 32'd0);
    chk("busy_and_done", 32'(both), 32'd0);
    chk("result", result, exp);
    chk("rd_out", 32'(rd_out), 32'(rd));
    chk("busy_at_done", 32'(busy), 32'd0);
    exp_hold = exp;
    rd_hold  = rd;
  endtask

  // Let the done cycle expire with start low; done must be a single pulse
  task automatic idle_gap();
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    rd_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases, issued back-to-back in each done cycle
    run_op(3'd0, 32'd7, 32'd6, 5'd5, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 0);
    run_op(3'd5, 32'd7, 32'd2, 5'd8, 0);
    run_op(3'd7, 32'd7, 32'd2, 5'd9, 0);
    idle_gap();
    run_op(3'd4, 32'd5, 32'd0, 5'd10, 0);
    run_op(3'd6, 32'd5, 32'd0, 5'd11, 0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 5'd12, 0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd13, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    idle_gap();

    // Stray start during iteration 10 is ignored
    run_op(3'd5, 32'd1000, 32'd7, 5'd15, 10);
    idle_gap();

    // Asynchronous reset mid-iteration drops the op without a done
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd123;
    op_b   = 32'd456;
    rd_in  = 5'd21;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = '0;
    rd_hold  = '0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("no_done_after_reset", 32'(ndone), 32'd0);
    run_op(3'd0, 32'd3, 32'd3, 5'd3, 0);
    idle_gap();

    // Randomized operations, with or without idle cycles between them
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom), rnd_op(), rnd_op(), 5'($urandom), 0);
      if ($urandom_range(0, 1) == 1) idle_gap();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
